// File: rtl/id_decode_queue.sv
// IF->ID instruction buffer: decodes the head entry into a control bundle,
// tracks the delay-slot flag and holds HI/LO users while the MDU is busy.
module id_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int MDU_LAT = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [31:0]            in_instr,
  input  logic                   in_exc,
  input  logic [4:0]             in_exccode,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic                   out_rfwr,
  output logic                   out_dmrd,
  output logic                   out_dmwr,
  output logic                   out_isbranch,
  output logic                   out_isbd,
  output logic                   out_start,
  output logic                   out_exception,
  output logic [4:0]             out_exccode,
  output logic                   mdu_busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = $clog2(MDU_LAT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [MW-1:0] LAT  = MW'(MDU_LAT);

  logic [PC_W-1:0] pcMem_q    [DEPTH];
  logic [31:0]     instrMem_q [DEPTH];
  logic            excMem_q   [DEPTH];
  logic [4:0]      codeMem_q  [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [MW-1:0] mduCnt_q, mduCnt_d;
  logic          bd_q, bd_d;
  logic          push, pop, hold;

  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  logic supported, rfwr, dmrd, dmwr, isBranch, start, hiLo, isBreak, isSys, headExc;

  assign out_pc    = pcMem_q[rdPtr_q];
  assign out_instr = instrMem_q[rdPtr_q];
  assign headExc   = excMem_q[rdPtr_q];
  assign op = out_instr[31:26];
  assign rs = out_instr[25:21];
  assign rt = out_instr[20:16];
  assign fn = out_instr[5:0];

  always_comb begin
    supported = 1'b0; rfwr = 1'b0; dmrd = 1'b0; dmwr = 1'b0; isBranch = 1'b0;
    start = 1'b0; hiLo = 1'b0; isBreak = 1'b0; isSys = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2b: begin supported = 1'b1; rfwr = 1'b1; end
          6'h08: begin supported = 1'b1; isBranch = 1'b1; end
          6'h09: begin supported = 1'b1; isBranch = 1'b1; rfwr = 1'b1; end
          6'h0c: begin supported = 1'b1; isSys = 1'b1; end
          6'h0d: begin supported = 1'b1; isBreak = 1'b1; end
          6'h10, 6'h12: begin supported = 1'b1; hiLo = 1'b1; rfwr = 1'b1; end
          6'h11, 6'h13: begin supported = 1'b1; hiLo = 1'b1; end
          6'h18, 6'h19, 6'h1a, 6'h1b: begin supported = 1'b1; hiLo = 1'b1; start = 1'b1; end
          default: ;
        endcase
      end
      // REGIMM: rt selects BLTZ/BGEZ and their linking forms
      6'h01: begin
        if (rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11) begin
          supported = 1'b1; isBranch = 1'b1; rfwr = rt[4];
        end
      end
      6'h02, 6'h04, 6'h05, 6'h06, 6'h07: begin supported = 1'b1; isBranch = 1'b1; end
      6'h03: begin supported = 1'b1; isBranch = 1'b1; rfwr = 1'b1; end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin supported = 1'b1; rfwr = 1'b1; end
      6'h10: begin
        if (rs == 5'h00) begin supported = 1'b1; rfwr = 1'b1; end
        else if (rs == 5'h04) supported = 1'b1;
        else if (rs == 5'h10 && fn == 6'h18) supported = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin supported = 1'b1; dmrd = 1'b1; rfwr = 1'b1; end
      6'h28, 6'h29, 6'h2b: begin supported = 1'b1; dmwr = 1'b1; end
      default: ;
    endcase
  end

  // A fetch-side exception outranks any decode-side cause
  always_comb begin
    out_exception = headExc || !supported || isBreak || isSys;
    if (headExc)        out_exccode = codeMem_q[rdPtr_q];
    else if (!supported) out_exccode = 5'h0a;
    else if (isBreak)   out_exccode = 5'h09;
    else if (isSys)     out_exccode = 5'h08;
    else                out_exccode = 5'h00;
  end

  assign out_rfwr     = rfwr  && !out_exception;
  assign out_dmrd     = dmrd  && !out_exception;
  assign out_dmwr     = dmwr  && !out_exception;
  assign out_start    = start && !out_exception;
  assign out_isbranch = isBranch;
  assign out_isbd     = bd_q;
  assign mdu_busy     = (mduCnt_q != '0);
  assign count        = count_q;
  assign in_ready     = (count_q != FULL);
  assign hold         = hiLo && mdu_busy && !out_exception;
  assign out_valid    = (count_q != '0) && !hold;
  assign push         = in_valid && in_ready && !flush;
  assign pop          = out_valid && out_ready;

  // The MDU countdown survives a flush: the issued operation still completes
  always_comb begin
    wrPtr_d = wrPtr_q; rdPtr_d = rdPtr_q; count_d = count_q; bd_d = bd_q; mduCnt_d = mduCnt_q;
    if (pop && out_start)    mduCnt_d = LAT;
    else if (mduCnt_q != '0) mduCnt_d = mduCnt_q - 1'b1;
    if (flush) begin
      wrPtr_d = '0; rdPtr_d = '0; count_d = '0; bd_d = 1'b0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop) begin
        rdPtr_d = rdPtr_q + 1'b1;
        bd_d    = out_isbranch;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0; rdPtr_q <= '0; count_q <= '0; bd_q <= 1'b0; mduCnt_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d; rdPtr_q <= rdPtr_d; count_q <= count_d; bd_q <= bd_d; mduCnt_q <= mduCnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem_q[wrPtr_q]    <= in_pc;
      instrMem_q[wrPtr_q] <= in_instr;
      excMem_q[wrPtr_q]   <= in_exc;
      codeMem_q[wrPtr_q]  <= in_exccode;
    end
  end
endmodule

// File: doc/id_decode_queue.md
Name: id_decode_queue

Overview:
- Parametrised successor to the ID-stage control decoder: a DEPTH-entry instruction buffer placed between IF and ID.
- Decodes the head entry into a compact control bundle and tracks the branch-delay-slot flag sequentially.
- Tracks HI/LO occupancy with an MDU countdown and stalls HI/LO-touching instructions while the MDU is busy.
- Raises RI/Bp/Sys exceptions with fetch-exception precedence.

Parameters:
DEPTH, 4, buffer entries; power of two, minimum 2
PC_W, 32, width of stored PC
MDU_LAT, 32, cycles HI/LO stay busy after a MULT/MULTU/DIV/DIVU issues; minimum 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  IF offers an entry
in_ready  out  1  buffer can accept an entry
in_pc  in  PC_W  fetch PC
in_instr  in  32  instruction word
in_exc  in  1  fetch-side exception
in_exccode  in  5  fetch-side ExcCode
flush  in  1  discard all buffered entries
out_valid  out  1  head entry is issuable
out_ready  in  1  EX accepts the head
out_pc  out  PC_W  head PC
out_instr  out  32  head instruction
out_rfwr  out  1  writes GPR (same opcode set as the existing decoder, including MFC0, JAL, BGEZAL/BLTZAL, JALR)
out_dmrd  out  1  load (LB/LBU/LH/LHU/LW)
out_dmwr  out  1  store (SB/SH/SW)
out_isbranch  out  1  branch or jump, including J/JAL/JR/JALR
out_isbd  out  1  head sits in a delay slot
out_start  out  1  MULT/MULTU/DIV/DIVU
out_exception  out  1  head carries an exception
out_exccode  out  5  ExcCode for the head
mdu_busy  out  1  HI/LO occupied
count  out  $clog2(DEPTH)+1  entries held

Behaviour:
Reset (rst=1, asynchronous):
- Pointers, count and the BD flag clear; MDU counter is 0.
- Outputs at reset: out_valid=0, in_ready=1, mdu_busy=0, count=0, out_isbd=0.
- Decode outputs follow the head slot contents, which are not reset.

Buffer:
- Circular FIFO with pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- in_ready = (count != DEPTH). It does not depend on a same-cycle pop, so a full buffer never accepts an entry.
- push = in_valid && in_ready; pop = out_valid && out_ready. When both occur, count is unchanged.
- Data written is visible at the head no earlier than the next cycle; there is no bypass.

Decode (combinational on the head entry):
- out_pc and out_instr are the stored values.

Exception priority:
1. Stored in_exc=1 -> out_exccode = stored code.
2. Otherwise, an instruction outside the supported set -> RI (5'h0a). The supported set is all ALU, shift, HI/LO, branch, jump, load/store, COP0 MFC0/MTC0/ERET, BREAK and SYSCALL encodings.
3. Otherwise BREAK -> Bp (5'h09).
4. Otherwise SYSCALL -> Sys (5'h08).
5. Otherwise out_exception=0 and out_exccode=0.
- When out_exception=1, out_rfwr, out_dmrd, out_dmwr and out_start are forced to 0.

HI/LO hazard:
- An HI/LO-class instruction is MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV or DIVU.
- hold = head is HI/LO-class && mdu_busy && !out_exception.
- out_valid = (count != 0) && !hold.

MDU counter:
- Width is $clog2(MDU_LAT+1).
- Loads MDU_LAT on a pop with out_start=1; otherwise decrements when nonzero.
- mdu_busy = (counter != 0).
- A MULT issued at cycle t blocks MFHI until cycle t+MDU_LAT inclusive; MFHI may issue at t+MDU_LAT+1.

Delay-slot flag:
- The BD register updates on each pop to out_isbranch of the popped entry.
- out_isbd = BD register.
- Exceptions do not alter this update.

Flush:
- Same cycle: count, pointers and the BD flag clear.
- A push in the same cycle is dropped and flush wins.
- out_valid goes to 0 the next cycle.
- The MDU counter is not cleared, because the in-flight operation completes.

Test Plan:
- Push ADDU, LW, SW with out_ready=1 -> issue in order one per cycle. out_rfwr=1,0,0; out_dmrd=0,1,0; out_dmwr=0,0,1; count returns to 0.
- DEPTH=4: push 5 entries with out_ready=0 -> in_ready=0 after the 4th, the 5th entry is not stored, count=4. Then pop all 4 -> pointers wrap and a fresh push lands correctly.
- MDU_LAT=3: MULT at cycle 10 then MFHI queued -> mdu_busy=1 for cycles 11-13, out_valid=0 for MFHI through cycle 13, MFHI issues at cycle 14.
- BEQ then ADDU then ADDU -> out_isbd=0, 1, 0 respectively.
- Head opcode 6'b111111 -> out_exception=1, out_exccode=0x0a, out_rfwr=0. With in_exc=1 and code 0x04 on a SYSCALL -> out_exccode=0x04.
- Flush with count=3 and concurrent in_valid, while MDU has 2 cycles left -> next cycle count=0, out_valid=0, mdu_busy still 1 for 1 cycle, out_isbd=0.
